// File: rtl/limn2600_bus_pkg.sv
// Shared types and constants for the Limn2600 single-beat memory bus.
// Used by the bus initiator and by the SRAM responder model.
package limn2600_bus_pkg;

    localparam int ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [ADDR_WIDTH-1:0] SERIAL_BASE = 32'hF800_0000;
    localparam logic [ADDR_WIDTH-1:0] ROM_BASE    = 32'hFFFE_0000;

    // Encoding 2'd3 is reserved and always reported as an error.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_ISSUE = 3'd2,
        WR_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/limn2600_bus_initiator_if.sv
// Core request/response and SRAM bus signals of the Limn2600 initiator.
// Handshake: a request transfers when req_valid && req_ready at posedge clk;
// resp_valid is a one-cycle pulse; bus_rdy answers one cycle after a sampled bus_cs.
interface limn2600_bus_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        bus_cs;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rdy;

    modport master (
        input  req_valid, req_we, req_size, req_addr, req_wdata, bus_rdata, bus_rdy,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bus_cs, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_addr, req_wdata, bus_rdata, bus_rdy,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bus_cs, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/limn2600_lane_unit.sv
// Little-endian byte-lane extraction and read-modify-write merge for
// sub-word accesses against a word-only responder.
module limn2600_lane_unit
    import limn2600_bus_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] lane_mask;

    assign shamt = {lane_i, 3'b000};

    always_comb begin
        case (size_i)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        lane_mask = mask << shamt;
        rdata_o   = (word_i >> shamt) & mask;
        merged_o  = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);
    end

endmodule

// File: rtl/limn2600_bus_initiator.sv
// Limn2600 bus initiator: one core load/store at a time onto word-only SRAM beats.
// Define LIMN2600_BUS_TRACE_EN to print a line per response and per timeout.
module limn2600_bus_initiator
    import limn2600_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    limn2600_bus_initiator_if.master  bus,
    output state_e                    dbg_state_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic                    bus_cs_q, bus_cs_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [31:0]             lane_rdata;
    logic [31:0]             lane_merged;
    logic                    timed_out;

    limn2600_lane_unit u_lane (
        .lane_i   (addr_q[1:0]),
        .size_i   (size_q),
        .word_i   (bus.bus_rdata),
        .wdata_i  (wdata_q),
        .rdata_o  (lane_rdata),
        .merged_o (lane_merged)
    );

    assign timed_out = ((state_q == RD_WAIT) || (state_q == WR_WAIT))
                       && !bus.bus_rdy && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        bus_cs_d     = 1'b0;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    size_d     = bus.req_size;
                    we_d       = bus.req_we;
                    wdata_d    = bus.req_wdata;
                    bus_addr_d = {bus.req_addr[31:2], 2'b00};
                    cnt_d      = '0;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                        bus_cs_d    = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_wdata_d = bus.req_wdata;
                        state_d     = WR_WAIT;
                    end else begin
                        // Loads, and the read half of a sub-word store.
                        bus_cs_d = 1'b1;
                        bus_we_d = 1'b0;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.bus_rdy) begin
                    if (we_q) begin
                        bus_cs_d    = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_wdata_d = lane_merged;
                        cnt_d       = '0;
                        state_d     = WR_ISSUE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = lane_rdata;
                        state_d      = RESP;
                    end
                end else if (timed_out) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_ISSUE: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.bus_rdy || timed_out) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = !bus.bus_rdy;
                    resp_rdata_d = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            bus_cs_q     <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            bus_cs_q     <= bus_cs_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.bus_cs     = bus_cs_q;
    assign bus.bus_we     = bus_we_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_wdata  = bus_wdata_q;
    assign dbg_state_o    = state_q;

`ifdef LIMN2600_BUS_TRACE_EN
    always @(posedge clk) begin
        if (!rst && resp_valid_q) begin
            $display("%m: %s addr=0x%8h data=0x%8h size=%0d err=%0d",
                     we_q ? "bus_write" : "bus_read", addr_q,
                     we_q ? wdata_q : resp_rdata_q, size_q, resp_err_q);
        end
        if (!rst && timed_out) begin
            $display("%m: bus_timeout addr=0x%8h", addr_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_limn2600_bus_initiator.sv
// Bench for limn2600_bus_initiator: SRAM responder model, request driver,
// scoreboard of expected responses, and a one-line report.
module tb_limn2600_bus_initiator;
    import limn2600_bus_pkg::*;

    localparam int TO = 4;
    localparam int W  = 77;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    limn2600_bus_initiator_if bus_if();
    state_e dbg_state;

    limn2600_bus_initiator #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM responder: rdy one cycle after a sampled cs
    logic        rsp_en    = 1'b1;
    logic        rsp_rdy   = 1'b0;
    logic        stray_rdy = 1'b0;
    logic [31:0] rsp_rdata = 32'h0;
    logic [31:0] mem [logic [29:0]];
    logic [31:0] model_mem [logic [29:0]];

    assign bus_if.bus_rdy   = rsp_rdy | stray_rdy;
    assign bus_if.bus_rdata = rsp_rdata;

    always @(posedge clk) begin
        rsp_rdy <= 1'b0;
        if (bus_if.bus_cs && rsp_en) begin
            rsp_rdy <= 1'b1;
            if (bus_if.bus_we) mem[bus_if.bus_addr[31:2]] = bus_if.bus_wdata;
            else rsp_rdata <= mem.exists(bus_if.bus_addr[31:2]) ? mem[bus_if.bus_addr[31:2]] : 32'h0;
        end
    end

    // reference model: {err, rdata, latency, beats, write-beat data}
    function automatic logic [W-1:0] model(input logic we, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] cur, rd, wd;
        logic        err;
        logic [7:0]  lat;
        logic [3:0]  beats;
        int          l;
        l   = int'(addr[1:0]);
        cur = model_mem.exists(addr[31:2]) ? model_mem[addr[31:2]] : 32'h0;
        rd  = 32'h0;
        wd  = 32'h0;
        err = 1'b0;
        if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) begin
            err = 1'b1; lat = 8'd1; beats = 4'd0;
        end else if (!rsp_en) begin
            err = 1'b1; lat = 8'(TO + 1); beats = 4'd1;
        end else if (!we) begin
            lat = 8'd3; beats = 4'd1;
            case (size)
                2'd0:    rd = {24'h0, cur[8*l +: 8]};
                2'd1:    rd = {16'h0, cur[8*l +: 16]};
                default: rd = cur;
            endcase
        end else if (size == 2'd2) begin
            lat = 8'd3; beats = 4'd1; wd = wdata;
            model_mem[addr[31:2]] = wdata;
        end else begin
            lat = 8'd5; beats = 4'd2; wd = cur;
            if (size == 2'd0) wd[8*l +: 8] = wdata[7:0];
            else              wd[8*l +: 16] = wdata[15:0];
            model_mem[addr[31:2]] = wd;
        end
        return {err, rd, lat, beats, wd};
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic         outstanding    = 1'b0;
    logic         chk_ready_next = 1'b0;
    logic         prev_cs        = 1'b0;
    int           acc_cyc        = 0;
    int           beats_seen     = 0;
    logic [31:0]  wd_seen        = 32'h0;
    int           consec         = 0;
    int           busy_ready     = 0;
    int           accepts        = 0;

    always @(negedge clk) begin
        if (rst) begin
            outstanding    = 1'b0;
            chk_ready_next = 1'b0;
            prev_cs        = 1'b0;
        end else begin
            if (chk_ready_next) begin
                check("ready_after_resp", 32'(bus_if.req_ready), 32'd1);
                chk_ready_next = 1'b0;
            end
            if (outstanding) begin
                if (bus_if.req_ready) busy_ready++;
                if (bus_if.bus_cs) begin
                    beats_seen++;
                    if (beats_seen == 1) check("first_beat_cycle", 32'(cyc - acc_cyc), 32'd1);
                    if (bus_if.bus_we) wd_seen = bus_if.bus_wdata;
                end
            end
            if (bus_if.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", bus_if.resp_rdata, e[75:44]);
                    check("resp_err", 32'(bus_if.resp_err), 32'(e[76]));
                    check("resp_latency", 32'(cyc - acc_cyc), 32'(e[43:36]));
                    check("bus_beats", 32'(beats_seen), 32'(e[35:32]));
                    check("write_beat_data", wd_seen, e[31:0]);
                end
                outstanding    = 1'b0;
                chk_ready_next = 1'b1;
            end
            if (bus_if.req_valid && bus_if.req_ready) begin
                outstanding = 1'b1;
                acc_cyc     = cyc;
                beats_seen  = 0;
                wd_seen     = 32'h0;
                accepts++;
            end
            if (bus_if.bus_cs && prev_cs) consec++;
            prev_cs = bus_if.bus_cs;
        end
    end

    // driver tasks (called at posedge + 1)
    task automatic wait_ready();
        int n = 0;
        while (!bus_if.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_if.req_ready) check("ready_wait", 32'd0, 32'd1);
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push);
        wait_ready();
        bus_if.req_we    = we;
        bus_if.req_size  = size;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_valid = 1'b1;
        if (push) exp_q.push_back(model(we, size, addr, wdata));
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((outstanding || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (outstanding || exp_q.size() != 0) begin
            check("resp_wait", 32'd0, 32'd1);
            exp_q.delete();
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
        send(we, size, addr, wdata, 1'b1);
        wait_done();
    endtask

    logic [31:0] rom_a;
    int          a0;
    int          n;

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_size  = 2'd0;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;
        rom_a = ROM_BASE;
        mem[rom_a[31:2]]       = 32'hCAFE_F00D;
        model_mem[rom_a[31:2]] = 32'hCAFE_F00D;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(bus_if.resp_err), 32'd0);
        check("rst_bus_cs", 32'(bus_if.bus_cs), 32'd0);
        check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed accesses
        xfer(1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        xfer(1'b0, 2'd2, 32'h0000_0010, 32'h0);
        xfer(1'b1, 2'd0, 32'h0000_0011, 32'h0000_00AA);
        xfer(1'b0, 2'd0, 32'h0000_0013, 32'h0);
        xfer(1'b0, 2'd1, 32'h0000_0012, 32'h0);
        xfer(1'b0, 2'd1, 32'h0000_0011, 32'h0);
        xfer(1'b0, 2'd2, 32'h0000_0012, 32'h0);
        xfer(1'b1, 2'd3, 32'h0000_0010, 32'h1234_5678);
        xfer(1'b1, 2'd1, 32'h0000_0012, 32'h0000_5A5A);
        xfer(1'b0, 2'd2, 32'h0000_0010, 32'h0);
        xfer(1'b0, 2'd2, rom_a, 32'h0);

        // responder silent: timeouts, no write beat for sub-word store
        rsp_en = 1'b0;
        xfer(1'b0, 2'd2, 32'h0000_0010, 32'h0);
        xfer(1'b1, 2'd0, 32'h0000_0011, 32'h0000_0055);
        rsp_en = 1'b1;
        xfer(1'b0, 2'd2, 32'h0000_0010, 32'h0);

        // reset while waiting for read data abandons the transaction
        rsp_en = 1'b0;
        send(1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_bus_cs", 32'(bus_if.bus_cs), 32'd0);
        check("abort_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus_if.req_ready), 32'd1);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        rsp_en = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end

        // stray rdy while idle
        stray_rdy = 1'b1;
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("stray_rdy_state", 32'(dbg_state), 32'(IDLE));
        check("stray_rdy_ready", 32'(bus_if.req_ready), 32'd1);

        // back-to-back: valid held, second request waits for IDLE
        a0 = accepts;
        bus_if.req_we    = 1'b0;
        bus_if.req_size  = 2'd2;
        bus_if.req_addr  = 32'h0000_0010;
        bus_if.req_valid = 1'b1;
        exp_q.push_back(model(1'b0, 2'd2, 32'h0000_0010, 32'h0));
        @(posedge clk); #1;
        bus_if.req_size = 2'd0;
        bus_if.req_addr = 32'h0000_0011;
        exp_q.push_back(model(1'b0, 2'd0, 32'h0000_0011, 32'h0));
        n = 0;
        while (!bus_if.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        wait_done();
        check("b2b_accepts", 32'(accepts - a0), 32'd2);

        // random traffic
        for (int i = 0; i < 30; i++) begin
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 32'h0000_0020 + 32'($urandom_range(0, 15)), $urandom);
        end

        check("cs_consecutive", 32'(consec), 32'd0);
        check("ready_while_busy", 32'(busy_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
